// File: rtl/symbol_unpacker.sv
// Buffers WIDTH-bit words in a DEPTH-entry FIFO and serialises each one into
// 2-bit symbols, MSB pair first, one per clock, for the sequence detector.
module symbol_unpacker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hold,
  output logic [1:0]                 num,
  output logic                       num_valid,
  output logic                       sym_last,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned LW   = PW + 1;
  localparam int unsigned NSYM = WIDTH / 2;
  localparam int unsigned IW   = $clog2(NSYM);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSYM - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        num_q, num_d;
  logic              last_q, last_d;
  logic              push, pop;
  logic [WIDTH-1:0]  head;

  assign in_ready  = (level_q != FULL_LVL);
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign num       = num_q;
  assign num_valid = (state_q == S_SHIFT);
  assign sym_last  = last_q;
  assign level     = level_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    num_d    = num_q;
    last_d   = last_q;
    pop      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!hold && level_q != '0) pop = 1'b1;
      end
      S_SHIFT: begin
        if (!hold) begin
          if (idx_q == LAST_IDX) begin
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              num_d   = '0;
              last_d  = 1'b0;
              idx_d   = '0;
            end
          end else begin
            sr_d   = sr_q << 2;
            idx_d  = idx_q + 1'b1;
            num_d  = sr_d[WIDTH-1 -: 2];
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pop is shared by the IDLE start and the back-to-back reload from SHIFT.
    if (pop) begin
      state_d  = S_SHIFT;
      sr_d     = head;
      idx_d    = '0;
      num_d    = head[WIDTH-1 -: 2];
      last_d   = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sr_q     <= '0;
      idx_q    <= '0;
      num_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is readable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_symbol_unpacker.sv
// Scoreboard bench for symbol_unpacker: a queue-based model predicts the
// symbol stream and per-cycle occupancy; a negedge monitor checks the DUT.
module tb_symbol_unpacker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NSYM  = WIDTH / 2;

  logic                    clk;
  logic                    rst_n;
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    hold;
  logic [1:0]              num;
  logic                    num_valid;
  logic                    sym_last;
  logic [$clog2(DEPTH):0]  level;

  symbol_unpacker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .num       (num),
    .num_valid (num_valid),
    .sym_last  (sym_last),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [WIDTH-1:0] fifoq[$];
  logic [2:0]       expq[$];
  bit               m_active    = 1'b0;
  int unsigned      m_rem       = 0;
  bit               m_hold_last = 1'b0;
  logic [2:0]       cur_exp     = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model of one clock edge: word queue plus remaining-symbol count.
  task automatic model_edge(input bit v, input logic [WIDTH-1:0] d, input bit h);
    int unsigned l0;
    logic [1:0]  s;
    l0 = fifoq.size();
    m_hold_last = h;
    if (!h) begin
      if (m_active) begin
        m_rem--;
        if (m_rem == 0) m_active = 1'b0;
      end
      if (!m_active && l0 > 0) begin
        fifoq.delete(0);
        m_active = 1'b1;
        m_rem    = NSYM;
      end
    end
    if (v && l0 < DEPTH) begin
      fifoq.push_back(d);
      for (int unsigned i = 0; i < NSYM; i++) begin
        s = 2'((d >> (WIDTH - 2 - 2 * i)) & 3);
        expq.push_back({(i == NSYM - 1) ? 1'b1 : 1'b0, s});
      end
    end
  endtask

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit h);
    in_valid = v;
    in_data  = d;
    hold     = h;
    @(posedge clk);
    model_edge(v, d, h);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_num"},       32'(num),       32'd0);
    chk({tag, "_num_valid"}, 32'(num_valid), 32'd0);
    chk({tag, "_sym_last"},  32'(sym_last),  32'd0);
    chk({tag, "_level"},     32'(level),     32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Asynchronous reset dropped between clock edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    fifoq.delete();
    expq.delete();
    m_active    = 1'b0;
    m_rem       = 0;
    m_hold_last = 1'b0;
    in_valid    = 1'b0;
    hold        = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("level",     32'(level),     32'(fifoq.size()));
      chk("in_ready",  32'(in_ready),  32'(fifoq.size() != DEPTH));
      chk("num_valid", 32'(num_valid), 32'(m_active));
      if (num_valid) begin
        if (!m_hold_last) begin
          if (expq.size() == 0) begin
            chk("sym_underrun", 32'(expq.size()), 32'd1);
          end else begin
            cur_exp = expq.pop_front();
            chk("num",      32'(num),      32'(cur_exp[1:0]));
            chk("sym_last", 32'(sym_last), 32'(cur_exp[2]));
          end
        end else begin
          chk("num_held",  32'(num),      32'(cur_exp[1:0]));
          chk("last_held", 32'(sym_last), 32'(cur_exp[2]));
        end
      end else begin
        chk("idle_num",  32'(num),      32'd0);
        chk("idle_last", 32'(sym_last), 32'd0);
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    hold     = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single word: 01,10,11,01 then idle.
    step(1'b1, 8'h6D, 1'b0);
    idle(6);

    // Back-to-back words without a bubble.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    idle(10);

    // Fill to full under hold; the fifth word must be dropped.
    step(1'b1, 8'h1B, 1'b1);
    step(1'b1, 8'hE4, 1'b1);
    step(1'b1, 8'h93, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_ready", 32'(in_ready), 32'd0);
    idle(20);

    // Hold for three cycles while num=10.
    step(1'b1, 8'h6D, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("pre_hold_num", 32'(num), 32'h2);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      chk("hold_num", 32'(num), 32'h2);
    end
    step(1'b0, '0, 1'b0);
    chk("post_hold_num", 32'(num), 32'h3);
    idle(6);

    // Push while level=3 coincides with a pop: level stays 3.
    step(1'b1, 8'h12, 1'b1);
    step(1'b1, 8'h34, 1'b1);
    step(1'b1, 8'h56, 1'b1);
    step(1'b1, 8'h78, 1'b0);
    chk("push_pop_level", 32'(level), 32'd3);
    idle(20);

    // Asynchronous reset mid-word with two words buffered.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd2);
    async_reset();
    idle(8);

    // Randomised traffic with occasional hold.
    for (int unsigned i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) == 0));
    end
    idle(4 * DEPTH * NSYM);
    chk("drained_expq", 32'(expq.size()), 32'd0);
    chk("drained_valid", 32'(num_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
